// File: rtl/instr_encoder_loader.sv
// Packs abstract RV32I instructions (ADD/ADDI/LW/SW) into 32-bit words and streams them into
// instruction memory through a small FIFO. Optional build macro: ENC_X0_DROP_EN.
module instr_encoder_loader #(
  parameter int DEPTH      = 64,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [1:0]    in_op,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [11:0]   in_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic [AW:0]   prog_len,
`ifdef ENC_X0_DROP_EN
  output logic [7:0]    drop_cnt,
`endif
  output logic          full
);
  // Handshake: a word is accepted on a rising edge where in_valid && in_ready;
  // in_ready never depends on in_valid.
  localparam int FW = $clog2(FIFO_DEPTH);
  localparam logic [1:0] OP_ADD = 2'b00, OP_ADDI = 2'b01, OP_LW = 2'b10, OP_SW = 2'b11;

  typedef enum logic {ST_RUN, ST_FULL} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fifo_mem_q [FIFO_DEPTH];
  logic [FW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FW:0]   cnt_q, cnt_d;
  logic [AW:0]   prog_len_q, prog_len_d;
  logic          imem_we_q, imem_we_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]   imem_wdata_q, imem_wdata_d;
  logic [31:0]   enc_word;
  logic          accept, push, pop;
`ifdef ENC_X0_DROP_EN
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          drop;
`endif

  always_comb begin
    enc_word = '0;
    case (in_op)
      OP_ADD:  enc_word = {7'b0, in_rs2, in_rs1, 3'b000, in_rd, 7'b0110011};
      OP_ADDI: enc_word = {in_imm, in_rs1, 3'b000, in_rd, 7'b0010011};
      OP_LW:   enc_word = {in_imm, in_rs1, 3'b010, in_rd, 7'b0000011};
      OP_SW:   enc_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], 7'b0100011};
      default: enc_word = '0;
    endcase
  end

  always_comb begin
    in_ready = (cnt_q != (FW+1)'(FIFO_DEPTH)) && !rst && !prog_start;
    accept   = in_valid && in_ready;
    push     = accept;
`ifdef ENC_X0_DROP_EN
    // Writes to x0 are architecturally dead; only the canonical NOP survives.
    drop = accept && (in_op != OP_SW) && (in_rd == 5'd0) &&
           !((in_op == OP_ADDI) && (in_rs1 == 5'd0) && (in_imm == 12'd0));
    if (drop) push = 1'b0;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
`endif
    pop          = (state_q == ST_RUN) && (cnt_q != '0);
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    cnt_d        = cnt_q;
    prog_len_d   = prog_len_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    if (prog_start) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      cnt_d      = '0;
      prog_len_d = '0;
      state_d    = ST_RUN;
    end else begin
      if (pop) begin
        imem_we_d    = 1'b1;
        imem_addr_d  = prog_len_q[AW-1:0];
        imem_wdata_d = fifo_mem_q[rd_ptr_q];
        rd_ptr_d     = rd_ptr_q + 1'b1;
        prog_len_d   = prog_len_q + 1'b1;
        if (prog_len_q == (AW+1)'(DEPTH - 1)) state_d = ST_FULL;
      end
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= enc_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      cnt_q        <= '0;
      prog_len_q   <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
`ifdef ENC_X0_DROP_EN
      drop_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      cnt_q        <= cnt_d;
      prog_len_q   <= prog_len_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
`ifdef ENC_X0_DROP_EN
      drop_cnt_q   <= drop_cnt_d;
`endif
    end
  end

  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign prog_len   = prog_len_q;
  assign full       = (prog_len_q == (AW+1)'(DEPTH));
`ifdef ENC_X0_DROP_EN
  assign drop_cnt   = drop_cnt_q;
`endif
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a queue-based behavioural model checked every cycle.
module tb_instr_encoder_loader;
  localparam int DEPTH      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int AW         = $clog2(DEPTH);

  logic          clk, rst, prog_start, in_valid, in_ready;
  logic [1:0]    in_op;
  logic [4:0]    in_rd, in_rs1, in_rs2;
  logic [11:0]   in_imm;
  logic          imem_we, full;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   prog_len;
`ifdef ENC_X0_DROP_EN
  logic [7:0]    drop_cnt;
`endif

  instr_encoder_loader #(.DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .prog_start(prog_start), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .prog_len(prog_len),
`ifdef ENC_X0_DROP_EN
    .drop_cnt(drop_cnt),
`endif
    .full(full)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [1:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [11:0] imm);
    case (op)
      2'd0:    return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
      2'd1:    return {imm, rs1, 3'b000, rd, 7'b0010011};
      2'd2:    return {imm, rs1, 3'b010, rd, 7'b0000011};
      default: return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] exp_q[$];
  int          m_len;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  int          m_drop;
  bit          started = 0;
  bit          m_acc;

  always @(posedge clk) begin
    started = 1;
    m_acc = in_valid && !rst && !prog_start && (exp_q.size() < FIFO_DEPTH);
    if (rst) begin
      exp_q.delete(); m_len = 0; m_we = 0; m_addr = 0; m_wdata = 0; m_drop = 0;
    end else if (prog_start) begin
      exp_q.delete(); m_len = 0; m_we = 0;
    end else begin
      m_we = 0;
      if (exp_q.size() > 0 && m_len < DEPTH) begin
        m_we = 1; m_addr = m_len; m_wdata = exp_q.pop_front(); m_len++;
      end
      if (m_acc) begin
`ifdef ENC_X0_DROP_EN
        if (in_op != 2'd3 && in_rd == 0 && !(in_op == 2'd1 && in_rs1 == 0 && in_imm == 0)) begin
          if (m_drop < 255) m_drop++;
        end else
`endif
        exp_q.push_back(enc(in_op, in_rd, in_rs1, in_rs2, in_imm));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] wlog [DEPTH];
  int wr_cnt = 0, run = 0, max_run = 0;

  always @(negedge clk) begin
    if (started) begin
      chk("imem_we", {31'd0, imem_we}, {31'd0, m_we});
      if (m_we) begin
        chk("imem_addr", 32'(imem_addr), m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
      end
      chk("prog_len", 32'(prog_len), m_len);
      chk("full", {31'd0, full}, {31'd0, (m_len == DEPTH)});
      chk("in_ready", {31'd0, in_ready},
          {31'd0, (!rst && !prog_start && exp_q.size() < FIFO_DEPTH)});
`ifdef ENC_X0_DROP_EN
      chk("drop_cnt", 32'(drop_cnt), m_drop);
`endif
      if (imem_we) begin
        wlog[imem_addr] = imem_wdata;
        wr_cnt++; run++;
        if (run > max_run) max_run = run;
      end else run = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm, output int tries);
    bit got = 0;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_valid = 1'b1;
    tries = 0;
    while (!got && tries < 20) begin
      @(negedge clk); got = in_ready; tries++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic restart();
    prog_start = 1'b1; tick(1); prog_start = 1'b0;
  endtask

  // ---------------- directed stimulus ----------------
  int t, total, snap;

  initial begin
    rst = 1'b1; prog_start = 1'b0; in_valid = 1'b0;
    in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", {31'd0, imem_we}, 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_len", 32'(prog_len), 32'd0);
    chk("rst_full", {31'd0, full}, 32'd0);
    @(posedge clk); #1;

    // single ADD right after reset
    send(2'd0, 5'd3, 5'd1, 5'd2, 12'd0, t);
    tick(3); @(negedge clk);
    chk("add_word", wlog[0], 32'h002081B3);
    chk("add_len", 32'(prog_len), 32'd1);
    chk("add_wr_cnt", wr_cnt, 32'd1);
    @(posedge clk); #1;

    // ADDI / LW / SW encodings
    restart();
    send(2'd1, 5'd5, 5'd0, 5'd0, 12'hFFF, t);
    send(2'd2, 5'd7, 5'd2, 5'd0, 12'd4, t);
    send(2'd3, 5'd0, 5'd2, 5'd6, 12'd8, t);
    tick(4); @(negedge clk);
    chk("addi_word", wlog[0], 32'hFFF00293);
    chk("lw_word", wlog[1], 32'h00412383);
    chk("sw_word", wlog[2], 32'h00612423);
    chk("three_len", 32'(prog_len), 32'd3);
    @(posedge clk); #1;

    // 16 back-to-back fill the whole memory
    restart();
    max_run = 0; total = 0;
    for (int i = 0; i < 16; i++) begin
      send(2'(i), 5'(i + 1), 5'(i), 5'(31 - i), 12'(i * 37), t);
      total += t;
    end
    tick(3); @(negedge clk);
    chk("b2b_no_stall", total, 32'd16);
    chk("b2b_run", max_run, 32'd16);
    chk("b2b_full", {31'd0, full}, 32'd1);
    chk("b2b_len", 32'(prog_len), 32'd16);
    @(posedge clk); #1;

    // memory full: FIFO absorbs FIFO_DEPTH words, then stalls
    snap = wr_cnt;
    in_op = 2'd0; in_rd = 5'd9; in_rs1 = 5'd8; in_rs2 = 5'd7; in_imm = '0; in_valid = 1'b1;
    tick(6);
    in_valid = 1'b0;
    @(negedge clk);
    chk("full_ready_low", {31'd0, in_ready}, 32'd0);
    chk("full_no_write", wr_cnt, snap);
    chk("full_len_hold", 32'(prog_len), 32'd16);
    @(posedge clk); #1;

    // prog_start with buffered words and a concurrent input
    in_op = 2'd3; in_rs1 = 5'd1; in_rs2 = 5'd2; in_imm = 12'd20; in_valid = 1'b1;
    prog_start = 1'b1; tick(1);
    prog_start = 1'b0; in_valid = 1'b0;
    snap = wr_cnt;
    tick(5); @(negedge clk);
    chk("flush_no_write", wr_cnt, snap);
    chk("flush_len", 32'(prog_len), 32'd0);
    chk("flush_full", {31'd0, full}, 32'd0);
    @(posedge clk); #1;
    send(2'd0, 5'd4, 5'd5, 5'd6, 12'd0, t);
    tick(3); @(negedge clk);
    chk("restart_word", wlog[0], 32'h00628233);
    chk("restart_len", 32'(prog_len), 32'd1);
    @(posedge clk); #1;

`ifdef ENC_X0_DROP_EN
    restart();
    snap = wr_cnt;
    send(2'd0, 5'd0, 5'd1, 5'd2, 12'd0, t);
    tick(3); @(negedge clk);
    chk("drop_no_write", wr_cnt, snap);
    chk("drop_cnt_one", 32'(drop_cnt), 32'd1);
    @(posedge clk); #1;
    send(2'd1, 5'd0, 5'd0, 5'd0, 12'd0, t);
    tick(3); @(negedge clk);
    chk("nop_word", wlog[0], 32'h00000013);
    chk("nop_len", 32'(prog_len), 32'd1);
    @(posedge clk); #1;
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
